shift_add_mult32: RTL and testbench
===================================

SHIFT_ADD_MULT32 -- requirements
Module: shift_add_mult32

Interface
REQ-001 SHALL use one clock and synchronous active-high reset; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 mcand  input  32  unsigned multiplicand, captured when start accepted.
REQ-006 mplier  input  32  unsigned multiplier, captured when start accepted.
REQ-007 addA  output  32  adder operand A, driven with the accumulator.
REQ-008 addB  output  32  adder operand B: captured mcand if current multiplier LSB=1, else 0.
REQ-009 addCin  output  1  adder carry-in, constant 0.
REQ-010 addSum  input  32  sum returned combinationally by the downstream 32-bit CLA in the same cycle.
REQ-011 addCout  input  1  carry-out returned by the same adder.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse: product valid.
REQ-014 product  output  64  registered unsigned product.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 at an edge SHALL load mcand register, mq<=mplier, acc<=0, count<=0, state<=RUN.
REQ-017 RUN, each edge: acc<={addCout, addSum[31:1]}, mq<={addSum[0], mq[31:1]}, count<=count+1.
REQ-018 Adder results SHALL be consumed in the cycle they are driven; no adder pipelining is assumed.
REQ-019 After the 32nd RUN edge (count=31), product<={new acc, new mq}, state<=DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Latency: start accepted at edge k -> done high during the cycle after edge k+32.
REQ-022 start SHALL be ignored in RUN and DONE; operands held internally, inputs may change freely.
REQ-023 start held continuously high SHALL be re-accepted on the first edge in IDLE after DONE, giving one result per 34 cycles.
REQ-024 product SHALL hold its value from DONE until the next result is written; it is never modified in RUN.
REQ-025 done SHALL never be high outside DONE; busy SHALL be 0 only in IDLE.
REQ-026 The 5-bit iteration counter SHALL not wrap into a 33rd iteration.

Reset
REQ-027 rst=1 at an edge SHALL force state=IDLE, acc=0, mq=0, count=0, mcand register=0, product=0, done=0, busy=0, overriding start.
REQ-028 rst mid-RUN SHALL abort the operation without producing done; the next start SHALL execute normally.

Configuration
REQ-029 Macro MULT_ZERO_BYPASS_EN SHALL control zero-operand bypass.
REQ-030 Defined: start accepted with mcand=0 or mplier=0 SHALL go IDLE->DONE directly with product<=0; done high the cycle after the accepting edge.
REQ-031 Undefined: zero operands SHALL take the full 32-iteration path and 33-cycle latency, still yielding 0.

Verification
REQ-032 mcand=3, mplier=5, start 1 cycle -> done 33 cycles later, product=64'h0000_0000_0000_000F.
REQ-033 mcand=mplier=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001; checks addCout shifted into acc.
REQ-034 Start 3x5, then start with 7x9 at RUN iteration 4 -> second start ignored, product=15, single done pulse.
REQ-035 rst at RUN iteration 10 -> next cycle busy=0, done=0, product=0; then 6x7 -> product=42 after 33 cycles.
REQ-036 mcand=0, mplier=32'h1234_5678 -> with MULT_ZERO_BYPASS_EN done 1 cycle after start; without, after 33; product=0 in both.
REQ-037 start held high over three operations with changing operands -> results at 34-cycle spacing, each matching the operands sampled at its accepting edge.

Source files
------------

// File: rtl/shift_add_mult32.sv
// 32x32 unsigned shift-add multiplier driving an external single-cycle adder.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands complete immediately.
module shift_add_mult32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [31:0] addA,
  output logic [31:0] addB,
  output logic        addCin,
  input  logic [31:0] addSum,
  input  logic        addCout,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mq_q, mq_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [4:0]          count_q, count_d;
  logic [2*DATA_W-1:0] product_q, product_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                zero_op;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (mcand == '0) || (mplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  // The external adder sees the accumulator and the conditionally gated multiplicand.
  assign addA    = acc_q;
  assign addB    = mq_q[0] ? mcand_q : '0;
  assign addCin  = 1'b0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = mcand;
          mq_d    = mplier;
          acc_d   = '0;
          count_d = '0;
          if (zero_op) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // Sum is consumed the same cycle; carry-out becomes the new acc MSB.
        acc_d   = {addCout, addSum[DATA_W-1:1]};
        mq_d    = {addSum[0], mq_q[DATA_W-1:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          product_d = {addCout, addSum[DATA_W-1:1], addSum[0], mq_q[DATA_W-1:1]};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mq_q      <= mq_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_shift_add_mult32.sv
// Randomized bench for shift_add_mult32 with a behavioural adder and product model.
module tb_shift_add_mult32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic [31:0] addA, addB, addSum;
  logic        addCin, addCout;
  logic        busy, done;
  logic [63:0] product;
  logic [32:0] sum_full;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream combinational adder.
  assign sum_full = {1'b0, addA} + {1'b0, addB} + {32'b0, addCin};
  assign addSum   = sum_full[31:0];
  assign addCout  = sum_full[32];

  shift_add_mult32 dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .addA(addA), .addB(addB), .addCin(addCin), .addSum(addSum), .addCout(addCout),
    .busy(busy), .done(done), .product(product)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic int zero_lat();
`ifdef MULT_ZERO_BYPASS_EN
    return 0;
`else
    return 32;
`endif
  endfunction

  // Stimulus helper: one start pulse, returns cycles from accept to done and the product.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] p);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    p = product;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mcand = 32'd3; mplier = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 || addA !== 32'd0 ||
        addB !== 32'd0 || addCin !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b product=%h addA=%h addB=%h addCin=%b, required all zero",
               busy, done, product, addA, addB, addCin);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic [63:0] p;
    do_op(32'd3, 32'd5, lat, p);
    vectors++;
    if (lat !== 32 || p !== 64'h0000_0000_0000_000F) begin
      miscompares++;
      $display("FAIL basic_3x5: lat=%0d product=%h, required lat=32 product=%h", lat, p, 64'hF);
    end
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
    vectors++;
    if (lat !== 32 || p !== 64'hFFFF_FFFE_0000_0001) begin
      miscompares++;
      $display("FAIL basic_max: lat=%0d product=%h, required lat=32 product=%h",
               lat, p, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_random();
    int lat; logic [63:0] p;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom | 32'h1;
      b = $urandom | 32'h8000_0000;
      if (i == 3) a = 32'h8000_0001;
      do_op(a, b, lat, p);
      vectors++;
      if (lat !== 32 || p !== ref_mul(a, b)) begin
        miscompares++;
        $display("FAIL random_%0d: %h*%h lat=%0d product=%h, required lat=32 product=%h",
                 i, a, b, lat, p, ref_mul(a, b));
      end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [63:0] p = '0;
    logic addcin_bad = 1'b0;
    start = 1'b1; mcand = 32'd3; mplier = 32'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (addCin !== 1'b0) addcin_bad = 1'b1;
    end
    start = 1'b1; mcand = 32'd7; mplier = 32'd9;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (done) begin pulses++; p = product; end
      @(posedge clk); @(negedge clk);
    end
    vectors++;
    if (pulses !== 1 || p !== 64'd15 || busy !== 1'b0 || addcin_bad) begin
      miscompares++;
      $display("FAIL ignore_start: pulses=%0d product=%h busy=%b addCin_bad=%b, required 1 pulse product=f busy=0",
               pulses, p, busy, addcin_bad);
    end
  endtask

  task automatic test_rst_mid_run();
    int lat; logic [63:0] p;
    logic early_done = 1'b0;
    start = 1'b1; mcand = 32'd11; mplier = 32'd13;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (done) early_done = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 || early_done) begin
      miscompares++;
      $display("FAIL rst_mid_run: busy=%b done=%b product=%h early_done=%b, required 0 0 0 0",
               busy, done, product, early_done);
    end
    rst = 1'b0;
    @(negedge clk);
    do_op(32'd6, 32'd7, lat, p);
    vectors++;
    if (lat !== 32 || p !== 64'd42) begin
      miscompares++;
      $display("FAIL after_rst_6x7: lat=%0d product=%h, required lat=32 product=%h", lat, p, 64'd42);
    end
  endtask

  task automatic test_zero();
    int lat; logic [63:0] p;
    logic [31:0] r;
    do_op(32'd9, 32'd9, lat, p);
    do_op(32'd0, 32'h1234_5678, lat, p);
    vectors++;
    if (lat !== zero_lat() || p !== 64'd0) begin
      miscompares++;
      $display("FAIL zero_mcand: lat=%0d product=%h, required lat=%0d product=0", lat, p, zero_lat());
    end
    r = $urandom | 32'h1;
    do_op(r, 32'd0, lat, p);
    vectors++;
    if (lat !== zero_lat() || p !== 64'd0) begin
      miscompares++;
      $display("FAIL zero_mplier: lat=%0d product=%h, required lat=%0d product=0", lat, p, zero_lat());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] b [3];
    int n, prev;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom | 32'h1;
      b[i] = $urandom | 32'h2;
    end
    start = 1'b1; mcand = a[0]; mplier = b[0];
    @(posedge clk); @(negedge clk);
    mcand = a[1]; mplier = b[1];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!done && n < 40) begin
        @(posedge clk); @(negedge clk); n++;
      end
      vectors++;
      if (done !== 1'b1 || product !== ref_mul(a[i], b[i])) begin
        miscompares++;
        $display("FAIL b2b_product_%0d: done=%b product=%h, required done=1 product=%h",
                 i, done, product, ref_mul(a[i], b[i]));
      end
      if (i > 0) begin
        vectors++;
        if (cyc - prev !== 34) begin
          miscompares++;
          $display("FAIL b2b_spacing_%0d: spacing=%0d, required 34", i, cyc - prev);
        end
      end
      prev = cyc;
      if (i == 2) begin
        start = 1'b0;
      end else begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        if (i == 0) begin mcand = a[2]; mplier = b[2]; end
        else begin mcand = $urandom; mplier = $urandom; end
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_ignore_start();
    test_rst_mid_run();
    test_zero();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
